// File: rtl/painterengine_gpu_clip_rect.sv
// Two-stage rectangle clipper: resolves the display size from the mode table or
// the custom registers, then emits the visible sub-rectangle of a placed texture.
module painterengine_gpu_clip_rect #(
    parameter int DATA_WIDTH = 16,
    parameter int MODE_WIDTH = 4
) (
    input  logic                  i_wire_clock,
    input  logic                  i_wire_reset,
    input  logic                  i_wire_cfg_we,
    input  logic [DATA_WIDTH-1:0] i_wire_cfg_width,
    input  logic [DATA_WIDTH-1:0] i_wire_cfg_height,
    input  logic                  i_wire_req_valid,
    output logic                  o_wire_req_ready,
    input  logic [MODE_WIDTH-1:0] i_wire_display_mode,
    input  logic [DATA_WIDTH-1:0] i_wire_image_width,
    input  logic [DATA_WIDTH-1:0] i_wire_image_height,
    input  logic [DATA_WIDTH-1:0] i_wire_dst_x,
    input  logic [DATA_WIDTH-1:0] i_wire_dst_y,
    output logic                  o_wire_clip_valid,
    input  logic                  i_wire_clip_ready,
    output logic [DATA_WIDTH-1:0] o_wire_src_x,
    output logic [DATA_WIDTH-1:0] o_wire_src_y,
    output logic [DATA_WIDTH-1:0] o_wire_dst_x0,
    output logic [DATA_WIDTH-1:0] o_wire_dst_y0,
    output logic [DATA_WIDTH-1:0] o_wire_clip_width,
    output logic [DATA_WIDTH-1:0] o_wire_clip_height,
    output logic                  o_wire_clip_empty
);

    // Two guard bits keep dst + size and a0 - dst exact for any 16-bit operands.
    localparam int EW = DATA_WIDTH + 2;

    logic                  advance;
    logic [DATA_WIDTH-1:0] cust_width;
    logic [DATA_WIDTH-1:0] cust_height;
    logic [DATA_WIDTH-1:0] disp_width;
    logic [DATA_WIDTH-1:0] disp_height;

    logic signed [EW-1:0] dst_x_ext, dst_y_ext;
    logic signed [EW-1:0] img_w_ext, img_h_ext;
    logic signed [EW-1:0] disp_w_ext, disp_h_ext;
    logic signed [EW-1:0] end_x, end_y;
    logic signed [EW-1:0] a0_x, a0_y, a1_x, a1_y;

    logic                 s1_valid;
    logic signed [EW-1:0] s1_a0_x, s1_a0_y, s1_a1_x, s1_a1_y;
    logic signed [EW-1:0] s1_dst_x, s1_dst_y;

    logic signed [EW-1:0] size_x, size_y, src_x, src_y;
    logic                 empty;

    assign advance          = !o_wire_clip_valid || i_wire_clip_ready;
    assign o_wire_req_ready = advance && !i_wire_reset;

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            cust_width  <= '0;
            cust_height <= '0;
        end else if (i_wire_cfg_we) begin
            cust_width  <= i_wire_cfg_width;
            cust_height <= i_wire_cfg_height;
        end
    end

    always_comb begin
        disp_width  = '0;
        disp_height = '0;
        if (i_wire_display_mode[MODE_WIDTH-1]) begin
            disp_width  = cust_width;
            disp_height = cust_height;
        end else begin
            case (i_wire_display_mode[2:0])
                3'd0: begin disp_width = DATA_WIDTH'(1280); disp_height = DATA_WIDTH'(720);  end
                3'd1: begin disp_width = DATA_WIDTH'(480);  disp_height = DATA_WIDTH'(272);  end
                3'd2: begin disp_width = DATA_WIDTH'(640);  disp_height = DATA_WIDTH'(480);  end
                3'd3: begin disp_width = DATA_WIDTH'(800);  disp_height = DATA_WIDTH'(480);  end
                3'd4: begin disp_width = DATA_WIDTH'(800);  disp_height = DATA_WIDTH'(600);  end
                3'd5: begin disp_width = DATA_WIDTH'(1024); disp_height = DATA_WIDTH'(768);  end
                3'd6: begin disp_width = DATA_WIDTH'(1920); disp_height = DATA_WIDTH'(1080); end
                default: begin disp_width = DATA_WIDTH'(128); disp_height = DATA_WIDTH'(64); end
            endcase
        end
    end

    always_comb begin
        dst_x_ext  = {{2{i_wire_dst_x[DATA_WIDTH-1]}}, i_wire_dst_x};
        dst_y_ext  = {{2{i_wire_dst_y[DATA_WIDTH-1]}}, i_wire_dst_y};
        img_w_ext  = {2'b00, i_wire_image_width};
        img_h_ext  = {2'b00, i_wire_image_height};
        disp_w_ext = {2'b00, disp_width};
        disp_h_ext = {2'b00, disp_height};
        end_x      = dst_x_ext + img_w_ext;
        end_y      = dst_y_ext + img_h_ext;
        a0_x       = dst_x_ext[EW-1] ? '0 : dst_x_ext;
        a0_y       = dst_y_ext[EW-1] ? '0 : dst_y_ext;
        a1_x       = (end_x < disp_w_ext) ? end_x : disp_w_ext;
        a1_y       = (end_y < disp_h_ext) ? end_y : disp_h_ext;
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            s1_valid <= 1'b0;
            s1_a0_x  <= '0;
            s1_a0_y  <= '0;
            s1_a1_x  <= '0;
            s1_a1_y  <= '0;
            s1_dst_x <= '0;
            s1_dst_y <= '0;
        end else if (advance) begin
            s1_valid <= i_wire_req_valid;
            if (i_wire_req_valid) begin
                s1_a0_x  <= a0_x;
                s1_a0_y  <= a0_y;
                s1_a1_x  <= a1_x;
                s1_a1_y  <= a1_y;
                s1_dst_x <= dst_x_ext;
                s1_dst_y <= dst_y_ext;
            end
        end
    end

    always_comb begin
        size_x = (s1_a1_x > s1_a0_x) ? (s1_a1_x - s1_a0_x) : '0;
        size_y = (s1_a1_y > s1_a0_y) ? (s1_a1_y - s1_a0_y) : '0;
        src_x  = s1_a0_x - s1_dst_x;
        src_y  = s1_a0_y - s1_dst_y;
        empty  = (size_x == '0) || (size_y == '0);
    end

    // An empty result zeroes every data field so downstream never sees stale offsets.
    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            o_wire_clip_valid  <= 1'b0;
            o_wire_src_x       <= '0;
            o_wire_src_y       <= '0;
            o_wire_dst_x0      <= '0;
            o_wire_dst_y0      <= '0;
            o_wire_clip_width  <= '0;
            o_wire_clip_height <= '0;
            o_wire_clip_empty  <= 1'b0;
        end else if (advance) begin
            o_wire_clip_valid <= s1_valid;
            if (s1_valid) begin
                o_wire_clip_empty <= empty;
                if (empty) begin
                    o_wire_src_x       <= '0;
                    o_wire_src_y       <= '0;
                    o_wire_dst_x0      <= '0;
                    o_wire_dst_y0      <= '0;
                    o_wire_clip_width  <= '0;
                    o_wire_clip_height <= '0;
                end else begin
                    o_wire_src_x       <= src_x[DATA_WIDTH-1:0];
                    o_wire_src_y       <= src_y[DATA_WIDTH-1:0];
                    o_wire_dst_x0      <= s1_a0_x[DATA_WIDTH-1:0];
                    o_wire_dst_y0      <= s1_a0_y[DATA_WIDTH-1:0];
                    o_wire_clip_width  <= size_x[DATA_WIDTH-1:0];
                    o_wire_clip_height <= size_y[DATA_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_clip_rect.sv
// Scoreboard bench for the rectangle clipper: an integer reference model predicts
// each accepted request, and a monitor compares results as they leave the DUT.
module tb_painterengine_gpu_clip_rect;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [15:0] cfg_width, cfg_height;
    logic        req_valid, req_ready;
    logic [3:0]  mode;
    logic [15:0] img_w, img_h, dst_x, dst_y;
    logic        clip_valid, clip_ready;
    logic [15:0] src_x, src_y, dst_x0, dst_y0, clip_w, clip_h;
    logic        clip_empty;

    typedef struct {
        logic [15:0] sx, sy, dx0, dy0, w, h;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    int          cust_w = 0;
    int          cust_h = 0;
    bit          stall_done;

    always #5 clk = ~clk;

    painterengine_gpu_clip_rect #(.DATA_WIDTH(16), .MODE_WIDTH(4)) dut (
        .i_wire_clock        (clk),
        .i_wire_reset        (rst),
        .i_wire_cfg_we       (cfg_we),
        .i_wire_cfg_width    (cfg_width),
        .i_wire_cfg_height   (cfg_height),
        .i_wire_req_valid    (req_valid),
        .o_wire_req_ready    (req_ready),
        .i_wire_display_mode (mode),
        .i_wire_image_width  (img_w),
        .i_wire_image_height (img_h),
        .i_wire_dst_x        (dst_x),
        .i_wire_dst_y        (dst_y),
        .o_wire_clip_valid   (clip_valid),
        .i_wire_clip_ready   (clip_ready),
        .o_wire_src_x        (src_x),
        .o_wire_src_y        (src_y),
        .o_wire_dst_x0       (dst_x0),
        .o_wire_dst_y0       (dst_y0),
        .o_wire_clip_width   (clip_w),
        .o_wire_clip_height  (clip_h),
        .o_wire_clip_empty   (clip_empty)
    );

    function automatic void axis(input int d, input int s, input int disp,
                                 output int n, output int src, output int a0);
        int a1;
        a0  = (d < 0) ? 0 : d;
        a1  = (d + s < disp) ? d + s : disp;
        n   = (a1 > a0) ? a1 - a0 : 0;
        src = a0 - d;
    endfunction

    function automatic exp_t model(input logic [3:0] m, input logic [15:0] iw, ih, dx, dy);
        exp_t r;
        int dw, dh, nx, ny, sx, sy, ax, ay;
        if (m[3]) begin
            dw = cust_w; dh = cust_h;
        end else begin
            case (m[2:0])
                3'd0: begin dw = 1280; dh = 720;  end
                3'd1: begin dw = 480;  dh = 272;  end
                3'd2: begin dw = 640;  dh = 480;  end
                3'd3: begin dw = 800;  dh = 480;  end
                3'd4: begin dw = 800;  dh = 600;  end
                3'd5: begin dw = 1024; dh = 768;  end
                3'd6: begin dw = 1920; dh = 1080; end
                default: begin dw = 128; dh = 64; end
            endcase
        end
        axis(int'($signed(dx)), int'(iw), dw, nx, sx, ax);
        axis(int'($signed(dy)), int'(ih), dh, ny, sy, ay);
        if (nx == 0 || ny == 0) begin
            r.sx = 0; r.sy = 0; r.dx0 = 0; r.dy0 = 0; r.w = 0; r.h = 0; r.e = 1'b1;
        end else begin
            r.sx = 16'(sx); r.sy = 16'(sy); r.dx0 = 16'(ax); r.dy0 = 16'(ay);
            r.w = 16'(nx); r.h = 16'(ny); r.e = 1'b0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && clip_valid && clip_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result: got sx=%0d sy=%0d w=%0d h=%0d, required no result",
                         src_x, src_y, clip_w, clip_h);
            end else begin
                mon_e = sb.pop_front();
                pops++;
                if ({src_x, src_y, dst_x0, dst_y0, clip_w, clip_h, clip_empty} !==
                    {mon_e.sx, mon_e.sy, mon_e.dx0, mon_e.dy0, mon_e.w, mon_e.h, mon_e.e}) begin
                    failures++;
                    $display("FAIL result: got src=(%0d,%0d) dst0=(%0d,%0d) size=%0dx%0d empty=%0b, required src=(%0d,%0d) dst0=(%0d,%0d) size=%0dx%0d empty=%0b",
                             src_x, src_y, dst_x0, dst_y0, clip_w, clip_h, clip_empty,
                             mon_e.sx, mon_e.sy, mon_e.dx0, mon_e.dy0, mon_e.w, mon_e.h, mon_e.e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] m, input logic [15:0] iw, ih, dx, dy,
                        input bit cfg = 1'b0, input logic [15:0] cw = 0, ch = 0);
        int n = 0;
        req_valid = 1'b1; mode = m; img_w = iw; img_h = ih; dst_x = dx; dst_y = dy;
        cfg_we = cfg; cfg_width = cw; cfg_height = ch;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, required 1", n);
            @(posedge clk);
        end else begin
            @(posedge clk);
            sb.push_back(model(m, iw, ih, dx, dy));
            if (cfg) begin
                cust_w = int'(cw); cust_h = int'(ch);
            end
        end
        #1;
        req_valid = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({req_ready, clip_valid, src_x, src_y, dst_x0, dst_y0, clip_w, clip_h, clip_empty} !== '0) begin
            failures++;
            $display("FAIL reset_state: got ready=%0b valid=%0b w=%0d h=%0d empty=%0b, required all 0",
                     req_ready, clip_valid, clip_w, clip_h, clip_empty);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %0b, required 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send(4'd2, 16'd100, 16'd50, 16'd600, 16'hFFEC);
        checks++;
        if (clip_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: got clip_valid=%0b one cycle after accept, required 0", clip_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({clip_valid, src_x, src_y, dst_x0, dst_y0, clip_w, clip_h, clip_empty} !==
            {1'b1, 16'd0, 16'd20, 16'd600, 16'd0, 16'd40, 16'd30, 1'b0}) begin
            failures++;
            $display("FAIL basic_clip: got valid=%0b src=(%0d,%0d) dst0=(%0d,%0d) size=%0dx%0d empty=%0b, required 1 (0,20) (600,0) 40x30 0",
                     clip_valid, src_x, src_y, dst_x0, dst_y0, clip_w, clip_h, clip_empty);
        end
        drain();
    endtask

    task automatic test_modes();
        send(4'd0, 16'd2000, 16'd800, 16'd0, 16'd0);
        send(4'd7, 16'd2000, 16'd800, 16'd0, 16'd0);
        send(4'd6, 16'd100, 16'd100, 16'd1900, 16'd1070);
        drain();
    endtask

    task automatic test_edges();
        send(4'd2, 16'd10, 16'd10, 16'd700, 16'd5);
        send(4'd2, 16'd10, 16'd10, 16'hFFF6, 16'd0);
        send(4'd2, 16'd10, 16'd10, 16'hFFF7, 16'd0);
        send(4'd2, 16'd0, 16'd10, 16'd5, 16'd5);
        send(4'd2, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000);
        send(4'd2, 16'hFFFF, 16'd10, 16'h7FFF, 16'd0);
        drain();
    endtask

    task automatic test_custom();
        send(4'b1000, 16'd400, 16'd400, 16'd0, 16'd0, 1'b1, 16'd320, 16'd240);
        send(4'b1000, 16'd400, 16'd400, 16'd0, 16'd0);
        send(4'b1101, 16'd400, 16'd400, 16'hFFF0, 16'd100);
        drain();
    endtask

    task automatic test_stall();
        logic [96:0] snap;
        int n;
        int pops0 = pops;
        clip_ready = 1'b0;
        stall_done = 1'b0;
        fork
            begin
                send(4'd4, 16'd50, 16'd60, 16'd10, 16'd20);
                send(4'd4, 16'd900, 16'd60, 16'hFFFB, 16'd590);
                send(4'd1, 16'd100, 16'd100, 16'd470, 16'hFFCE);
                stall_done = 1'b1;
            end
        join_none
        repeat (3) @(posedge clk);
        #1;
        snap = {clip_valid, src_x, src_y, dst_x0, dst_y0, clip_w, clip_h};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({clip_valid, src_x, src_y, dst_x0, dst_y0, clip_w, clip_h} !== snap ||
                clip_valid !== 1'b1 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold: got valid=%0b ready=%0b w=%0d h=%0d, required held valid=1 ready=0",
                         clip_valid, req_ready, clip_w, clip_h);
            end
        end
        @(posedge clk); #1;
        clip_ready = 1'b1;
        n = 0;
        while (!stall_done && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        drain();
        checks++;
        if (pops - pops0 != 3) begin
            failures++;
            $display("FAIL stall_count: got %0d results, required 3", pops - pops0);
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        t0 = $time;
        for (int i = 0; i < 6; i++)
            send(4'($urandom_range(0, 8)), 16'($urandom_range(0, 2000)),
                 16'($urandom_range(0, 1200)), 16'($urandom), 16'($urandom_range(0, 1500)));
        checks++;
        if ($time - t0 != 60) begin
            failures++;
            $display("FAIL back_to_back: got %0t for 6 accepts, required 60", $time - t0);
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        clip_ready = 1'b0;
        send(4'd2, 16'd100, 16'd100, 16'd0, 16'd0);
        send(4'd3, 16'd100, 16'd100, 16'd5, 16'd5);
        rst = 1'b1;
        cfg_we = 1'b1; cfg_width = 16'd50; cfg_height = 16'd50;
        sb.delete();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_reset: got %0b, required 0", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({clip_valid, src_x, src_y, dst_x0, dst_y0, clip_w, clip_h, clip_empty} !== '0) begin
            failures++;
            $display("FAIL reset_flush: got valid=%0b w=%0d h=%0d empty=%0b, required all 0",
                     clip_valid, clip_w, clip_h, clip_empty);
        end
        rst = 1'b0; cfg_we = 1'b0;
        cust_w = 0; cust_h = 0;
        clip_ready = 1'b1;
        send(4'b1000, 16'd100, 16'd100, 16'd0, 16'd0);
        send(4'd2, 16'd100, 16'd50, 16'd600, 16'hFFEC);
        drain();
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_width = 0; cfg_height = 0;
        req_valid = 1'b0; mode = 0; img_w = 0; img_h = 0; dst_x = 0; dst_y = 0;
        clip_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_modes();
        test_edges();
        test_custom();
        test_stall();
        test_back_to_back();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
